// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game sequencer. Picks a hole pseudo-randomly,
// lights it for a bounded time, scores hits/misses and flashes successful hits.
// Latency: a button press acts on the 3rd clock edge after the pin rises; LED
// commands are decoded combinationally from the registered state.
// No backpressure: inputs are sampled every cycle, outputs are level/pulse.
//
// Ports:
//   clock        system clock, all state on its rising edge
//   reset        asynchronous active-low reset
//   start        level input; a rising edge while idle begins a game
//   buttons[8:0] asynchronous active-high hole buttons, bit i = hole i
//   led_commands 9 x 16-bit command words, hole i at [16i+15:16i]
//   busy         high while a game is in progress (GAP/UP/FLASH)
//   done         one-cycle pulse when a game completes
//   score        hits this game (saturating)
//   misses       misses this game (saturating)
//   mole_idx     hole currently lit (0-8), holds its last value otherwise
//
// Build option: define MOLE_PENALTY_EN to count wrong-hole presses in UP as
// misses. Without it, wrong-hole presses are ignored.

module mole_scheduler #(
  parameter int TICK_DIV    = 50000,
  parameter int GAP_TICKS   = 200,
  parameter int UP_TICKS    = 500,
  parameter int FLASH_TICKS = 100,
  parameter int ROUNDS      = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [8:0]   buttons,
  output logic [143:0] led_commands,
  output logic         busy,
  output logic         done,
  output logic [7:0]   score,
  output logic [7:0]   misses,
  output logic [3:0]   mole_idx
);

  localparam logic [15:0] CMD_OFF   = 16'h0000;
  localparam logic [15:0] CMD_MOLE  = 16'h00FF;
  localparam logic [15:0] CMD_HIT   = 16'hFF00;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_GU    = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
  localparam int MAX_TICKS = (MAX_GU > FLASH_TICKS) ? MAX_GU : FLASH_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int RW        = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_FLASH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Control strobes produced by the next-state logic.
  logic new_game;
  logic load_idx;
  logic score_inc;
  logic miss_inc;
  logic round_inc;
  logic state_chg;

  // ---------------------------------------------------------------------------
  // Start edge detect (start is a synchronous level input)
  // ---------------------------------------------------------------------------
  logic start_q;
  logic start_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) start_q <= 1'b0;
    else        start_q <= start;
  end

  assign start_rise = start & ~start_q;

  // ---------------------------------------------------------------------------
  // Button path: two-flop synchronizer, then a third flop for edge detect.
  // press is valid in the cycle after the 2nd edge, so it acts on the 3rd.
  // ---------------------------------------------------------------------------
  logic [8:0] sync1_q, sync2_q, sync3_q;
  logic [8:0] press;
  logic [8:0] target_mask;
  logic       hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign press       = sync2_q & ~sync3_q;
  assign target_mask = 9'b1 << mole_idx;
  assign hit         = |(press & target_mask);

`ifdef MOLE_PENALTY_EN
  logic wrong;
  assign wrong = |(press & ~target_mask);
`endif

  // ---------------------------------------------------------------------------
  // Hole selection LFSR: x^16 + x^14 + x^13 + x^11 + 1, right-shifting
  // Fibonacci form. Maximal length, so a nonzero seed never reaches zero.
  // Free-running every cycle, including while idle.
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_q;
  logic [3:0]  lfsr_nib;
  logic [3:0]  next_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Fold 0..15 onto 0..8; values 9..15 map to 0..6.
  assign lfsr_nib = lfsr_q[3:0];
  assign next_idx = (lfsr_nib < 4'd9) ? lfsr_nib : (lfsr_nib - 4'd9);

  // ---------------------------------------------------------------------------
  // Prescaler and per-state tick counter. Both restart on every state change,
  // which makes each state last exactly N ticks from entry (a hit can enter
  // FLASH mid-tick, so the prescaler phase must be reset there too).
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [TW-1:0] tick_q;
  logic          gap_end;
  logic          up_end;
  logic          flash_end;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                presc_q <= '0;
    else if (state_chg || tick) presc_q <= '0;
    else                       presc_q <= presc_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         tick_q <= '0;
    else if (state_chg) tick_q <= '0;
    else if (tick)      tick_q <= tick_q + 1'b1;
  end

  assign gap_end   = tick && (tick_q == TW'(GAP_TICKS - 1));
  assign up_end    = tick && (tick_q == TW'(UP_TICKS - 1));
  assign flash_end = tick && (tick_q == TW'(FLASH_TICKS - 1));

  // ---------------------------------------------------------------------------
  // Round counter: a round ends on UP timeout or at the end of FLASH; the
  // UP->FLASH hit transition stays inside the same round.
  // ---------------------------------------------------------------------------
  logic [RW-1:0] round_q;
  logic          last_round;

  assign last_round = (round_q == RW'(ROUNDS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    new_game  = 1'b0;
    load_idx  = 1'b0;
    score_inc = 1'b0;
    miss_inc  = 1'b0;
    round_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d  = S_GAP;
          new_game = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d  = S_UP;
          load_idx = 1'b1;
        end
      end
      S_UP: begin
        // A hit wins over a timeout landing in the same cycle.
        if (hit) begin
          state_d   = S_FLASH;
          score_inc = 1'b1;
        end else if (up_end) begin
          state_d   = last_round ? S_DONE : S_GAP;
          miss_inc  = 1'b1;
          round_inc = 1'b1;
        end
`ifdef MOLE_PENALTY_EN
        else if (wrong) begin
          miss_inc = 1'b1;
        end
`endif
      end
      S_FLASH: begin
        if (flash_end) begin
          state_d   = last_round ? S_DONE : S_GAP;
          round_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_chg = (state_d != state_q);

  // ---------------------------------------------------------------------------
  // Score, misses, round count, lit hole
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      score    <= '0;
      misses   <= '0;
      round_q  <= '0;
      mole_idx <= '0;
    end else begin
      if (new_game) begin
        score   <= '0;
        misses  <= '0;
        round_q <= '0;
      end else begin
        if (score_inc && (score != 8'hFF))  score  <= score + 1'b1;
        if (miss_inc && (misses != 8'hFF))  misses <= misses + 1'b1;
        if (round_inc)                      round_q <= round_q + 1'b1;
      end
      if (load_idx) mole_idx <= next_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_GAP) || (state_q == S_UP) || (state_q == S_FLASH);
    done = (state_q == S_DONE);
  end

  always_comb begin
    led_commands = '0;
    for (int i = 0; i < 9; i++) begin
      led_commands[16*i +: 16] = CMD_OFF;
      if (mole_idx == 4'(i)) begin
        if (state_q == S_UP)    led_commands[16*i +: 16] = CMD_MOLE;
        if (state_q == S_FLASH) led_commands[16*i +: 16] = CMD_HIT;
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: randomized self-checking bench for mole_scheduler.
// Expected values come from game-timeline arithmetic and an LFSR sequence
// function; stimulus timing, idle gaps and wrong holes are drawn from $urandom.

module tb_mole_scheduler;

  localparam int TICK_DIV    = 4;
  localparam int GAP_TICKS   = 2;
  localparam int UP_TICKS    = 3;
  localparam int FLASH_TICKS = 2;
  localparam int ROUNDS      = 2;

  // Derived phase lengths in clock cycles.
  localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;    // 8
  localparam int UP_CYC    = UP_TICKS * TICK_DIV;     // 12
  localparam int FLASH_CYC = FLASH_TICKS * TICK_DIV;  // 8

`ifdef MOLE_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  localparam logic [15:0] W_MOLE = 16'h00FF;
  localparam logic [15:0] W_HIT  = 16'hFF00;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [8:0]   buttons;
  logic [143:0] led_commands;
  logic         busy;
  logic         done;
  logic [7:0]   score;
  logic [7:0]   misses;
  logic [3:0]   mole_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  mole_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .GAP_TICKS  (GAP_TICKS),
    .UP_TICKS   (UP_TICKS),
    .FLASH_TICKS(FLASH_TICKS),
    .ROUNDS     (ROUNDS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .buttons     (buttons),
    .led_commands(led_commands),
    .busy        (busy),
    .done        (done),
    .score       (score),
    .misses      (misses),
    .mole_idx    (mole_idx)
  );

  always #5 clock = ~clock;

  // Number of rising edges seen since reset was last released; the hole LFSR
  // has advanced exactly this many times.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hole chosen from the LFSR after n advances from seed 16'hACE1.
  function automatic int exp_idx(input int n);
    int l;
    int b;
    l = 'hACE1;
    for (int i = 0; i < n; i++) begin
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
    l = l & 15;
    return (l < 9) ? l : l - 9;
  endfunction

  function automatic logic [143:0] led_exp(input int idx, input logic [15:0] w);
    logic [143:0] r;
    r = '0;
    r[16*idx +: 16] = w;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_busy"},   144'(busy), 144'(0));
    check_eq({pfx, "_done"},   144'(done), 144'(0));
    check_eq({pfx, "_score"},  144'(score), 144'(0));
    check_eq({pfx, "_misses"}, 144'(misses), 144'(0));
    check_eq({pfx, "_idx"},    144'(mole_idx), 144'(0));
    check_eq({pfx, "_leds"},   led_commands, 144'(0));
  endtask

  // Called one ns after an edge; returns the edge count at GAP entry.
  task automatic start_game(output int g);
    start = 1'b1;
    step(1);
    start = 1'b0;
    g = cyc;
  endtask

  // Bounded wait for the done pulse; t = edge count when seen, -1 if never.
  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (done) begin
        t = cyc;
        return;
      end
    end
  endtask

  initial begin
    int g, a, m, w, d, t, b;
    bit bad;

    reset   = 1'b0;
    start   = 1'b0;
    buttons = '0;
    #20;
    check_reset_vals("por");
    #2 reset = 1'b1;
    step(1 + int'($urandom_range(0, 20)));

    // ---- Game 1: no presses, both moles time out ----
    start_game(g);
    check_eq("g1_busy_gap", 144'(busy), 144'(1));
    check_eq("g1_score_clr", 144'(score), 144'(0));
    step(GAP_CYC - 1);
    check_eq("g1_gap_leds_off", led_commands, 144'(0));
    step(1);
    m = exp_idx(g + GAP_CYC - 1);
    check_eq("g1_idx1", 144'(mole_idx), 144'(m));
    check_eq("g1_idx1_range", 144'(mole_idx < 4'd9), 144'(1));
    check_eq("g1_mole_lit", led_commands, led_exp(m, W_MOLE));
    step(UP_CYC - 1);
    check_eq("g1_mole_still_lit", led_commands, led_exp(m, W_MOLE));
    step(1);
    check_eq("g1_timeout_leds", led_commands, 144'(0));
    check_eq("g1_misses1", 144'(misses), 144'(1));
    step(GAP_CYC);
    m = exp_idx(g + 2 * GAP_CYC + UP_CYC - 1);
    check_eq("g1_idx2", 144'(mole_idx), 144'(m));
    check_eq("g1_idx2_range", 144'(mole_idx < 4'd9), 144'(1));
    step(UP_CYC - 1);
    check_eq("g1_done_early", 144'(done), 144'(0));
    step(1);
    check_eq("g1_done_pulse", 144'(done), 144'(1));
    check_eq("g1_busy_low", 144'(busy), 144'(0));
    check_eq("g1_misses2", 144'(misses), 144'(2));
    check_eq("g1_score0", 144'(score), 144'(0));
    step(1);
    check_eq("g1_done_once", 144'(done), 144'(0));
    check_eq("g1_misses_hold", 144'(misses), 144'(2));

    // ---- Game 2: hit the lit hole at a random point in UP ----
    step(1 + int'($urandom_range(0, 15)));
    start_game(g);
    step(GAP_CYC);
    m = exp_idx(g + GAP_CYC - 1);
    check_eq("g2_idx", 144'(mole_idx), 144'(m));
    d = int'($urandom_range(0, 8));
    step(d);
    buttons = 9'(1) << m;
    step(2);
    check_eq("g2_score_pre", 144'(score), 144'(0));
    check_eq("g2_mole_pre", led_commands, led_exp(m, W_MOLE));
    step(1);
    a = cyc;
    check_eq("g2_score_hit", 144'(score), 144'(1));
    buttons = '0;
    bad = 1'b0;
    for (int i = 0; i < FLASH_CYC; i++) begin
      if (led_commands !== led_exp(m, W_HIT)) bad = 1'b1;
      step(1);
    end
    check_eq("g2_flash_8cyc", 144'(bad), 144'(0));
    check_eq("g2_after_flash_off", led_commands, 144'(0));
    check_eq("g2_after_flash_busy", 144'(busy), 144'(1));
    wait_done(t);
    check_eq("g2_done_time", 144'(t), 144'(a + FLASH_CYC + GAP_CYC + UP_CYC));
    check_eq("g2_final_score", 144'(score), 144'(1));
    check_eq("g2_final_misses", 144'(misses), 144'(1));
    check_eq("g2_idx_round2", 144'(mole_idx), 144'(exp_idx(a + FLASH_CYC + GAP_CYC - 1)));

    // ---- Game 3: wrong hole, then a hit landing on the timeout edge ----
    step(1 + int'($urandom_range(0, 15)));
    start_game(g);
    step(GAP_CYC);
    m = exp_idx(g + GAP_CYC - 1);
    w = (m + 1 + int'($urandom_range(0, 7))) % 9;
    buttons = 9'(1) << w;
    step(3);
    check_eq("g3_wrong_misses", 144'(misses), 144'(PEN));
    check_eq("g3_wrong_score", 144'(score), 144'(0));
    check_eq("g3_wrong_still_lit", led_commands, led_exp(m, W_MOLE));
    buttons = '0;
    step(UP_CYC - 3 - 3);
    buttons = 9'(1) << m;
    step(2);
    check_eq("g3_last_up_lit", led_commands, led_exp(m, W_MOLE));
    check_eq("g3_last_up_score", 144'(score), 144'(0));
    step(1);
    check_eq("g3_edge_hit_score", 144'(score), 144'(1));
    check_eq("g3_edge_hit_misses", 144'(misses), 144'(PEN));
    check_eq("g3_edge_hit_flash", led_commands, led_exp(m, W_HIT));
    buttons = '0;
    wait_done(t);
    check_eq("g3_done_time", 144'(t), 144'(g + GAP_CYC + UP_CYC + FLASH_CYC + GAP_CYC + UP_CYC));
    check_eq("g3_final_misses", 144'(misses), 144'(1 + PEN));

    // ---- Game 4: presses outside UP, then reset mid-UP ----
    step(1 + int'($urandom_range(0, 15)));
    start_game(g);
    b = int'($urandom_range(0, 8));
    buttons = 9'(1) << b;
    step(4);
    check_eq("g4_gap_press_score", 144'(score), 144'(0));
    check_eq("g4_gap_press_misses", 144'(misses), 144'(0));
    check_eq("g4_gap_press_leds", led_commands, 144'(0));
    buttons = '0;
    step(GAP_CYC - 4);
    m = exp_idx(g + GAP_CYC - 1);
    check_eq("g4_idx", 144'(mole_idx), 144'(m));
    step(2);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("midup_rst");
    repeat (2) @(posedge clock);
    #4 reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (done || busy) bad = 1'b1;
    end
    check_eq("g4_idle_after_rst", 144'(bad), 144'(0));
    start_game(g);
    check_eq("g4_restart_busy", 144'(busy), 144'(1));
    check_eq("g4_restart_leds", led_commands, 144'(0));
    step(GAP_CYC);
    check_eq("g4_restart_idx", 144'(mole_idx), 144'(exp_idx(g + GAP_CYC - 1)));
    wait_done(t);
    check_eq("g4_done_time", 144'(t), 144'(g + 2 * (GAP_CYC + UP_CYC)));
    check_eq("g4_final_misses", 144'(misses), 144'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
